parc_core_pipe_muldiv: RTL

PARC_CORE_PIPE_MULDIV -- requirements
Module: parc_core_pipe_muldiv

---
 rtl/parc_core_pipe_muldiv_if.sv | 34 +++
 rtl/parc_core_pipe_muldiv.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/parc_core_pipe_muldiv_if.sv
// Request/response bundle for the pipelined multiply/divide unit.
// Master issues fn/a/b/val and accepts results; slave is the unit.
interface parc_core_pipe_muldiv_if;
  logic [2:0]  muldivreq_msg_fn;
  logic [31:0] muldivreq_msg_a;
  logic [31:0] muldivreq_msg_b;
  logic        muldivreq_val;
  logic        muldivreq_rdy;
  logic [63:0] muldivresp_msg_result;
  logic        muldivresp_val;
  logic        muldivresp_rdy;

  modport master (
    output muldivreq_msg_fn,
    output muldivreq_msg_a,
    output muldivreq_msg_b,
    output muldivreq_val,
    input  muldivreq_rdy,
    input  muldivresp_msg_result,
    input  muldivresp_val,
    output muldivresp_rdy
  );

  modport slave (
    input  muldivreq_msg_fn,
    input  muldivreq_msg_a,
    input  muldivreq_msg_b,
    input  muldivreq_val,
    output muldivreq_rdy,
    output muldivresp_msg_result,
    output muldivresp_val,
    input  muldivresp_rdy
  );
endinterface

// File: rtl/parc_core_pipe_muldiv.sv
// 4-stage pipelined 32x32 mul / div / rem unit (X, M, X2, X3).
// Ports: clk, reset (async low), stall_* holds, io (slave bundle).
module parc_core_pipe_muldiv (
  input logic clk,
  input logic reset,
  input logic stall_Xhl,
  input logic stall_Mhl,
  input logic stall_X2hl,
  input logic stall_X3hl,
  parc_core_pipe_muldiv_if.slave io
);

  localparam logic [2:0] FN_MUL  = 3'd0;
  localparam logic [2:0] FN_DIV  = 3'd1;
  localparam logic [2:0] FN_DIVU = 3'd2;
  localparam logic [2:0] FN_REM  = 3'd3;
  localparam logic [2:0] FN_REMU = 3'd4;

  // acc: product accumulator, or {remainder, dividend/quotient}
  // m:   magnitude of multiplicand or divisor
  // opb: multiplier bits not yet consumed (MSB first)
  typedef struct packed {
    logic [2:0]  fn;
    logic        sa;
    logic        sb;
    logic [63:0] acc;
    logic [31:0] m;
    logic [31:0] opb;
  } stage_t;

  function automatic stage_t f_step8(input stage_t s);
    stage_t      t;
    logic [32:0] hi;
    logic [32:0] trial;
    t = s;
    for (int i = 0; i < 8; i++) begin
      if (t.fn == FN_MUL) begin
        t.acc = {t.acc[62:0], 1'b0} +
                (t.opb[31] ? {32'd0, t.m} : 64'd0);
        t.opb = {t.opb[30:0], 1'b0};
      end else begin
        // 33-bit trial so the shifted remainder never loses its MSB
        hi    = t.acc[63:31];
        trial = hi - {1'b0, t.m};
        if (trial[32])
          t.acc = {hi[31:0], t.acc[30:0], 1'b0};
        else
          t.acc = {trial[31:0], t.acc[30:0], 1'b1};
      end
    end
    return t;
  endfunction

  logic   r_v1, r_v2, r_v3, r_v4;
  stage_t r_s1, r_s2, r_s3, r_s4;

  stage_t      w_d;
  logic        w_vd;
  logic        w_sgn;
  logic [31:0] w_ma;
  logic [31:0] w_mb;
  logic        w_ld1, w_ld2, w_ld3, w_ld4;
  stage_t      w_n1, w_n2, w_n3, w_n4;
  logic [63:0] w_res;
  logic        w_unused;

  assign io.muldivreq_rdy = reset & ~stall_Xhl;
  assign w_vd = io.muldivreq_val & io.muldivreq_rdy;

  always_comb begin
    w_sgn = (io.muldivreq_msg_fn == FN_MUL) |
            (io.muldivreq_msg_fn == FN_DIV) |
            (io.muldivreq_msg_fn == FN_REM);
    w_d    = '0;
    w_d.fn = io.muldivreq_msg_fn;
    w_d.sa = w_sgn & io.muldivreq_msg_a[31];
    w_d.sb = w_sgn & io.muldivreq_msg_b[31];
    w_ma   = w_d.sa ? -io.muldivreq_msg_a : io.muldivreq_msg_a;
    w_mb   = w_d.sb ? -io.muldivreq_msg_b : io.muldivreq_msg_b;
    if (io.muldivreq_msg_fn == FN_MUL) begin
      w_d.acc = 64'd0;
      w_d.m   = w_ma;
      w_d.opb = w_mb;
    end else begin
      w_d.acc = {32'd0, w_ma};
      w_d.m   = w_mb;
      w_d.opb = 32'd0;
    end
  end

  assign w_n1 = f_step8(w_d);
  assign w_n2 = f_step8(r_s1);
  assign w_n3 = f_step8(r_s2);
  assign w_n4 = f_step8(r_s3);

  assign w_ld1 = ~stall_Xhl;
  assign w_ld2 = ~stall_Mhl;
  assign w_ld3 = ~stall_X2hl;
  // X3 also holds while a valid result waits on the consumer
  assign w_ld4 = ~stall_X3hl & ~(r_v4 & ~io.muldivresp_rdy);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
      r_v3 <= 1'b0;
      r_v4 <= 1'b0;
    end else begin
      if (w_ld1) r_v1 <= w_vd;
      if (w_ld2) r_v2 <= r_v1;
      if (w_ld3) r_v3 <= r_v2;
      if (w_ld4) r_v4 <= r_v3;
    end
  end

  // datapath is never reset; val bits alone qualify it
  always_ff @(posedge clk) begin
    if (w_ld1) r_s1 <= w_n1;
    if (w_ld2) r_s2 <= w_n2;
    if (w_ld3) r_s3 <= w_n3;
    if (w_ld4) r_s4 <= w_n4;
  end

  always_comb begin
    w_res = r_s4.acc;
    case (r_s4.fn)
      FN_MUL:
        w_res = (r_s4.sa ^ r_s4.sb) ? -r_s4.acc : r_s4.acc;
      FN_DIV, FN_REM: begin
        w_res[63:32] = r_s4.sa ? -r_s4.acc[63:32]
                               : r_s4.acc[63:32];
        w_res[31:0]  = (r_s4.sa ^ r_s4.sb) ? -r_s4.acc[31:0]
                                           : r_s4.acc[31:0];
      end
      FN_DIVU, FN_REMU: w_res = r_s4.acc;
      default:          w_res = r_s4.acc;
    endcase
  end

  assign io.muldivresp_msg_result = w_res;
  assign io.muldivresp_val        = r_v4;
  assign w_unused = ^{r_s4.m, r_s4.opb};

endmodule
